// File: rtl/mlp_stream_sequencer.sv
// mlp_stream_sequencer
// Sequences one MLP job: first loads 2*cfg_beats kernel words into the kernel
// BRAM, then streams cfg_vectors dot products of cfg_beats activation beats
// each toward the MLP, and finally waits for one result per dot product.
//
// Ports
//   clk, reset_n                 : clock, asynchronous active-low reset
//   start, cfg_beats, cfg_vectors: job request; configuration latched on start
//   kernel_din/valid/ready       : kernel word stream (accepted in LOAD only)
//   act_data/valid/ready         : 128-bit activation beat stream (STREAM only)
//   bram_wr_addr, bram_blk_wr_addr, bram_din, bram_wren : kernel BRAM write port
//   bram_rd_addr                 : kernel BRAM read address, one cycle after a beat
//   mlp_din, mlp_din_sof/eof     : MLP input, two cycles after a beat
//   mlp_dout, mlp_dout_valid     : MLP result return (no backpressure)
//   res_data, res_valid          : registered copy of each MLP result
//   busy, done, cfg_error        : job status
module mlp_stream_sequencer #(
    parameter int DATA_WIDTH      = 64,
    parameter int BRAM_ADDR_WIDTH = 10,
    parameter int BRAM_DATA_WIDTH = 64
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         start,
    input  logic [BRAM_ADDR_WIDTH-2:0]   cfg_beats,
    input  logic [15:0]                  cfg_vectors,
    input  logic [BRAM_DATA_WIDTH-1:0]   kernel_din,
    input  logic                         kernel_valid,
    output logic                         kernel_ready,
    input  logic [127:0]                 act_data,
    input  logic                         act_valid,
    output logic                         act_ready,
    output logic [BRAM_ADDR_WIDTH-1:0]   bram_wr_addr,
    output logic [6:0]                   bram_blk_wr_addr,
    output logic [BRAM_DATA_WIDTH-1:0]   bram_din,
    output logic                         bram_wren,
    output logic [BRAM_ADDR_WIDTH-2:0]   bram_rd_addr,
    output logic [143:0]                 mlp_din,
    output logic                         mlp_din_sof,
    output logic                         mlp_din_eof,
    input  logic [DATA_WIDTH-1:0]        mlp_dout,
    input  logic                         mlp_dout_valid,
    output logic [DATA_WIDTH-1:0]        res_data,
    output logic                         res_valid,
    output logic                         busy,
    output logic                         done,
    output logic                         cfg_error
);

    localparam int BW = BRAM_ADDR_WIDTH - 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;
    localparam logic [1:0] S_DRAIN  = 2'd3;

    logic [1:0]                 r_state;
    logic [BW-1:0]              r_cfg_beats;
    logic [15:0]                r_cfg_vectors;
    logic [BRAM_ADDR_WIDTH-1:0] r_load_cnt;
    logic [BW-1:0]              r_beat_idx;
    logic [15:0]                r_vec_issued;
    logic [15:0]                r_res_cnt;
    logic                       r_done;
    logic                       r_cfg_error;

    logic                       r_wren;
    logic [BRAM_ADDR_WIDTH-1:0] r_wr_addr;
    logic [BRAM_DATA_WIDTH-1:0] r_bram_din;

    logic                       r_s1_valid;
    logic [127:0]               r_s1_data;
    logic                       r_s1_sof;
    logic                       r_s1_eof;
    logic [BW-1:0]              r_rd_addr;
    logic [143:0]               r_mlp_din;
    logic                       r_sof;
    logic                       r_eof;

    logic [DATA_WIDTH-1:0]      r_res_data;
    logic                       r_res_valid;

    logic                       w_kernel_acc;
    logic                       w_act_ready;
    logic                       w_act_acc;
    logic                       w_beat_last;
    logic                       w_load_last;
    logic                       w_cfg_ok;

    // act_ready is a pure function of the issued count, so it falls in the
    // cycle right after the final beat of the final vector is taken.
    assign w_kernel_acc = (r_state == S_LOAD) && kernel_valid;
    assign w_act_ready  = (r_state == S_STREAM) && (r_vec_issued < r_cfg_vectors);
    assign w_act_acc    = w_act_ready && act_valid;
    assign w_beat_last  = (r_beat_idx == (r_cfg_beats - BW'(1)));
    assign w_load_last  = (r_load_cnt == ({r_cfg_beats, 1'b0} - BRAM_ADDR_WIDTH'(1)));
    assign w_cfg_ok     = (cfg_beats != '0) && (cfg_vectors != '0);

    // Job control: state, latched configuration and all job counters.
    // Results are counted only while a job is streaming or draining.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_cfg_beats   <= '0;
            r_cfg_vectors <= '0;
            r_load_cnt    <= '0;
            r_beat_idx    <= '0;
            r_vec_issued  <= '0;
            r_res_cnt     <= '0;
            r_done        <= 1'b0;
            r_cfg_error   <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_cfg_error <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_cfg_ok) begin
                            r_cfg_beats   <= cfg_beats;
                            r_cfg_vectors <= cfg_vectors;
                            r_load_cnt    <= '0;
                            r_beat_idx    <= '0;
                            r_vec_issued  <= '0;
                            r_res_cnt     <= '0;
                            r_state       <= S_LOAD;
                        end else begin
                            r_cfg_error <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (w_kernel_acc) begin
                        r_load_cnt <= r_load_cnt + BRAM_ADDR_WIDTH'(1);
                        if (w_load_last) begin
                            r_state <= S_STREAM;
                        end
                    end
                end
                S_STREAM: begin
                    if (w_act_acc) begin
                        if (w_beat_last) begin
                            r_beat_idx   <= '0;
                            r_vec_issued <= r_vec_issued + 16'd1;
                            if ((r_vec_issued + 16'd1) == r_cfg_vectors) begin
                                r_state <= S_DRAIN;
                            end
                        end else begin
                            r_beat_idx <= r_beat_idx + BW'(1);
                        end
                    end
                end
                default: begin
                    if (r_res_cnt == r_cfg_vectors) begin
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
            endcase
            if (mlp_dout_valid && ((r_state == S_STREAM) || (r_state == S_DRAIN))) begin
                r_res_cnt <= r_res_cnt + 16'd1;
            end
        end
    end

    // Kernel BRAM write port: one registered write per accepted kernel word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wren     <= 1'b0;
            r_wr_addr  <= '0;
            r_bram_din <= '0;
        end else begin
            r_wren <= w_kernel_acc;
            if (w_kernel_acc) begin
                r_wr_addr  <= r_load_cnt;
                r_bram_din <= kernel_din;
            end
        end
    end

    // Two-stage activation pipeline. Stage 1 lines the beat up with the BRAM
    // read of its kernel word; stage 2 presents it to the MLP. Idle cycles
    // push zeros so the MLP accumulator adds nothing.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_sof   <= 1'b0;
            r_s1_eof   <= 1'b0;
            r_rd_addr  <= '0;
            r_mlp_din  <= '0;
            r_sof      <= 1'b0;
            r_eof      <= 1'b0;
        end else begin
            r_s1_valid <= w_act_acc;
            if (w_act_acc) begin
                r_s1_data <= act_data;
                r_s1_sof  <= (r_beat_idx == '0);
                r_s1_eof  <= w_beat_last;
                r_rd_addr <= r_beat_idx;
            end
            r_mlp_din <= r_s1_valid ? {16'h0, r_s1_data} : '0;
            r_sof     <= r_s1_valid && r_s1_sof;
            r_eof     <= r_s1_valid && r_s1_eof;
        end
    end

    // Result forwarding: every returned MLP word is registered, in any state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
        end else begin
            r_res_valid <= mlp_dout_valid;
            if (mlp_dout_valid) begin
                r_res_data <= mlp_dout;
            end
        end
    end

    assign kernel_ready     = (r_state == S_LOAD);
    assign act_ready        = w_act_ready;
    assign bram_wr_addr     = r_wr_addr;
    assign bram_blk_wr_addr = 7'd0;
    assign bram_din         = r_bram_din;
    assign bram_wren        = r_wren;
    assign bram_rd_addr     = r_rd_addr;
    assign mlp_din          = r_mlp_din;
    assign mlp_din_sof      = r_sof;
    assign mlp_din_eof      = r_eof;
    assign res_data         = r_res_data;
    assign res_valid        = r_res_valid;
    assign busy             = (r_state != S_IDLE);
    assign done             = r_done;
    assign cfg_error        = r_cfg_error;

endmodule

// File: doc/mlp_stream_sequencer.md
MLP_STREAM_SEQUENCER -- requirements
Module: mlp_stream_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, meaning the result width returned by the MLP.
REQ-002 SHALL have parameter BRAM_ADDR_WIDTH, default 10, meaning the kernel BRAM word-address width.
REQ-003 SHALL have parameter BRAM_DATA_WIDTH, default 64, meaning the kernel word width.
REQ-004 SHALL use one clock and an asynchronous active-low reset; ports clk (in, 1, clock) and reset_n (in, 1, async active-low reset).
REQ-005 SHALL have port start  in  1  begins a job; sampled in IDLE only.
REQ-006 SHALL have port cfg_beats  in  BRAM_ADDR_WIDTH-1  beats per dot product, latched on start.
REQ-007 SHALL have port cfg_vectors  in  16  dot products per job, latched on start.
REQ-008 SHALL have ports kernel_din  in  BRAM_DATA_WIDTH; kernel_valid  in  1; kernel_ready  out  1: kernel word stream.
REQ-009 SHALL have ports act_data  in  128; act_valid  in  1; act_ready  out  1: activation beat stream.
REQ-010 SHALL have ports bram_wr_addr  out  BRAM_ADDR_WIDTH; bram_blk_wr_addr  out  7; bram_din  out  BRAM_DATA_WIDTH; bram_wren  out  1.
REQ-011 SHALL have ports bram_rd_addr  out  BRAM_ADDR_WIDTH-1; mlp_din  out  144; mlp_din_sof  out  1; mlp_din_eof  out  1.
REQ-012 SHALL have ports mlp_dout  in  DATA_WIDTH; mlp_dout_valid  in  1: MLP result return.
REQ-013 SHALL have ports res_data  out  DATA_WIDTH; res_valid  out  1; busy  out  1; done  out  1; cfg_error  out  1.

Function
REQ-014 SHALL implement states IDLE, LOAD, STREAM, DRAIN; busy high in all states except IDLE.
REQ-015 IDLE: start with cfg_beats>0 and cfg_vectors>0 -> LOAD, write address cleared; start with either field zero -> stay IDLE, cfg_error pulses one cycle.
REQ-016 LOAD: kernel_ready=1; each kernel_valid&kernel_ready cycle registers bram_wren=1, bram_din=kernel_din, bram_wr_addr=current count (0 upward) one cycle later; bram_blk_wr_addr always 0.
REQ-017 LOAD SHALL end after exactly 2*cfg_beats accepted words, then go to STREAM; kernel_ready=0 outside LOAD.
REQ-018 STREAM: act_ready=1 while vectors issued < cfg_vectors; beat index k runs 0..cfg_beats-1, wraps to 0 after the last beat and increments vectors issued.
REQ-019 Beat k accepted in cycle t SHALL drive bram_rd_addr=k in cycle t+1 and mlp_din={16'h0,act_data}, mlp_din_sof=(k==0), mlp_din_eof=(k==cfg_beats-1) in cycle t+2.
REQ-020 Cycles without an accepted beat SHALL produce mlp_din=0, sof=0, eof=0 two cycles later (accumulator adds zero); bram_rd_addr holds its last value.
REQ-021 cfg_beats==1 SHALL assert sof and eof on the same beat.
REQ-022 When vectors issued reaches cfg_vectors, act_ready SHALL drop in the same cycle as the last acceptance completes (combinational on count) and state -> DRAIN.
REQ-023 Every mlp_dout_valid cycle (any state) SHALL register res_data=mlp_dout, res_valid=1 next cycle; no backpressure; results received counter increments in STREAM/DRAIN.
REQ-024 DRAIN: when results received == cfg_vectors, done pulses one cycle and state -> IDLE; results in IDLE are forwarded but not counted.
REQ-025 start while busy SHALL be ignored; cfg inputs are not re-sampled mid-job.
REQ-026 Counters SHALL be wide enough for 2^(BRAM_ADDR_WIDTH-1) beats and 65535 vectors without overflow.

Reset
REQ-027 reset_n low SHALL asynchronously force IDLE, all counters 0, and every output 0 (including mlp_din, bram_rd_addr, bram_wr_addr, res_data).
REQ-028 Reset asserted mid-job SHALL abandon the job with no done pulse; first job after release behaves as from power-up.

Verification
REQ-029 cfg_beats=4, cfg_vectors=1, 8 kernel words back-to-back -> bram_wren 8 cycles, addresses 0..7, then STREAM.
REQ-030 4 beats back-to-back -> bram_rd_addr 0,1,2,3 from t+1; mlp_din sof with beat 0, eof with beat 3 at t+2; one mlp_dout_valid -> res_valid then done.
REQ-031 act_valid toggling 1,0,1,0 -> zero mlp_din on gap cycles, sof/eof still on beats 0 and 3 only.
REQ-032 cfg_beats=1, cfg_vectors=3 -> three beats each with sof=eof=1; done only after third result.
REQ-033 start with cfg_vectors=0 -> cfg_error one-cycle pulse, busy stays 0.
REQ-034 reset_n low during STREAM beat 2 -> outputs 0 immediately; new job after release completes normally.
